// File: rtl/rr_mult_opseq_if.sv
// Handshake bundle for the online-multiplier operand sequencer.
// The bench or upstream logic uses the master side and the sequencer uses the slave side.
interface rr_mult_opseq_if #(
    parameter int D  = 3,
    parameter int W  = 3,
    parameter int IW = 4
);
    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic [D-1:0]   x_in;
    logic [D-1:0]   y_in;
    logic           out_valid;
    logic           out_ready;
    logic [D*W-1:0] a_x;
    logic [D*W-1:0] a_y;
    logic [D-1:0]   b_x;
    logic [D-1:0]   b_y;
    logic [IW-1:0]  iter;
    logic           last;
    logic           done;

    modport master (
        output start, in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, a_x, a_y, b_x, b_y, iter, last, done
    );

    modport slave (
        input  start, in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, a_x, a_y, b_x, b_y, iter, last, done
    );
endinterface

// File: rtl/rr_mult_opseq.sv
// Digit-serial MSDF operand sequencer: builds truncated X/Y prefixes and emits
// one operand-pair beat per iteration through a single output register.
//
// state | meaning
// IDLE  | waiting for start; no digits accepted
// RUN   | accepting operand digits 0..N-1
// FLUSH | emitting DELTA zero-digit beats, then waiting for the last handoff
module rr_mult_opseq #(
    parameter int RADIX = 4,
    parameter int J     = 0,
    parameter int N     = 8,
    parameter int DELTA = 2
) (
    input  logic              clk,
    input  logic              rst,
    rr_mult_opseq_if.slave    bus
);
    localparam int D  = $clog2(RADIX) + 1;
    localparam int W  = J + 3;
    localparam int IW = $clog2(N + DELTA + 1);
    localparam logic [IW-1:0] K_LAST_DIG  = IW'(N - 1);
    localparam logic [IW-1:0] K_LAST_BEAT = IW'(N + DELTA - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  cnt;
    logic [D*W-1:0] x_pre, y_pre, x_ins, y_ins;
    logic           out_free, in_ready_c, accept, emit_fl, finish, clear;

    assign out_free    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = in_ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (accept && cnt == K_LAST_DIG) state_nx = FLUSH;
            FLUSH:   if (finish) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        accept     = 1'b0;
        emit_fl    = 1'b0;
        finish     = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE:  clear = bus.start;
            RUN: begin
                in_ready_c = out_free;
                accept     = bus.in_valid && out_free;
            end
            FLUSH: begin
                emit_fl = out_free && (cnt <= K_LAST_BEAT);
                finish  = bus.out_valid && bus.out_ready && bus.last;
            end
            default: ;
        endcase
    end

    // Digit k lands in slot W-1-k; digits past the window are dropped.
    always_comb begin
        x_ins = x_pre;
        y_ins = y_pre;
        for (int s = 0; s < W; s++) begin
            if (int'(cnt) == W - 1 - s) begin
                x_ins[s*D +: D] = bus.x_in;
                y_ins[s*D +: D] = bus.y_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_pre <= '0;
            y_pre <= '0;
            cnt   <= '0;
        end else if (clear) begin
            x_pre <= '0;
            y_pre <= '0;
            cnt   <= '0;
        end else if (accept) begin
            x_pre <= x_ins;
            y_pre <= y_ins;
            cnt   <= cnt + 1'b1;
        end else if (emit_fl) begin
            cnt   <= cnt + 1'b1;
        end
    end

    // a_x carries X[j-1] (pre-update), a_y carries Y[j] (post-insert).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.a_x       <= '0;
            bus.a_y       <= '0;
            bus.b_x       <= '0;
            bus.b_y       <= '0;
            bus.iter      <= '0;
            bus.last      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= finish;
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.a_x       <= x_pre;
                bus.a_y       <= y_ins;
                bus.b_x       <= bus.x_in;
                bus.b_y       <= bus.y_in;
                bus.iter      <= cnt;
                bus.last      <= 1'b0;
            end else if (emit_fl) begin
                bus.out_valid <= 1'b1;
                bus.a_x       <= x_pre;
                bus.a_y       <= y_pre;
                bus.b_x       <= '0;
                bus.b_y       <= '0;
                bus.iter      <= cnt;
                bus.last      <= (cnt == K_LAST_BEAT);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_mult_opseq.sv
// Randomized and directed bench for rr_mult_opseq: a prefix model computes
// every expected beat from the received digits; one process checks each cycle.
module tb_rr_mult_opseq;
    localparam int RADIX = 4;
    localparam int J     = 0;
    localparam int N     = 4;
    localparam int DELTA = 2;
    localparam int D     = 3;
    localparam int W     = 3;
    localparam int IW    = 3;
    localparam int NB    = N + DELTA;

    typedef struct packed {
        logic [D*W-1:0] ax;
        logic [D*W-1:0] ay;
        logic [D-1:0]   bx;
        logic [D-1:0]   by;
        logic [IW-1:0]  iter;
        logic           last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_mult_opseq_if #(.D(D), .W(W), .IW(IW)) bus ();

    rr_mult_opseq #(.RADIX(RADIX), .J(J), .N(N), .DELTA(DELTA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    beat_t          exp_q[$];
    logic [D-1:0]   cur_x[N];
    logic [D-1:0]   cur_y[N];
    logic [D*W-1:0] log_ax[NB];
    logic [D*W-1:0] log_ay[NB];
    logic [D-1:0]   log_bx[NB];
    logic [D-1:0]   log_by[NB];
    logic           log_last[NB];

    int  bp_hold    = 0;
    bit  rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Prefix windows recomputed from scratch for every iteration j.
    function automatic void model_push();
        for (int j = 0; j < NB; j++) begin
            beat_t b;
            b = '0;
            for (int i = 0; i < N; i++) begin
                if (i < W) begin
                    if (i < j)  b.ax[(W-1-i)*D +: D] = cur_x[i];
                    if (i <= j) b.ay[(W-1-i)*D +: D] = cur_y[i];
                end
            end
            if (j < N) begin
                b.bx = cur_x[j];
                b.by = cur_y[j];
            end
            b.iter = IW'(j);
            b.last = (j == NB - 1);
            exp_q.push_back(b);
        end
    endfunction

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_hold > 0) begin
                bus.out_ready = 1'b0;
                bp_hold--;
            end else if (rand_ready) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Per-cycle compare process.
    initial begin
        bit    done_due;
        bit    stall_prev;
        beat_t prev_vec;
        beat_t cur;
        beat_t e;
        done_due   = 1'b0;
        stall_prev = 1'b0;
        prev_vec   = '0;
        forever begin
            @(negedge clk);
            cur = '{bus.a_x, bus.a_y, bus.b_x, bus.b_y, bus.iter, bus.last};
            if (rst) begin
                done_due   = 1'b0;
                stall_prev = 1'b0;
            end else begin
                chk("done", 32'(bus.done), 32'(done_due));
                if (stall_prev) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_data", 32'(cur), 32'(prev_vec));
                end
                if (bus.out_valid && !bus.out_ready)
                    chk("in_ready_stall", 32'(bus.in_ready), 32'd0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got iter %0d expected no beat at %0t", bus.iter, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("iter", 32'(bus.iter), 32'(e.iter));
                        chk("a_x", 32'(bus.a_x), 32'(e.ax));
                        chk("a_y", 32'(bus.a_y), 32'(e.ay));
                        chk("b_x", 32'(bus.b_x), 32'(e.bx));
                        chk("b_y", 32'(bus.b_y), 32'(e.by));
                        chk("last", 32'(bus.last), 32'(e.last));
                        if (int'(bus.iter) < NB) begin
                            log_ax[bus.iter]   = bus.a_x;
                            log_ay[bus.iter]   = bus.a_y;
                            log_bx[bus.iter]   = bus.b_x;
                            log_by[bus.iter]   = bus.b_y;
                            log_last[bus.iter] = bus.last;
                        end
                    end
                end
                done_due   = bus.out_valid && bus.out_ready && bus.last;
                stall_prev = bus.out_valid && !bus.out_ready;
                prev_vec   = cur;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        for (int i = 0; i < NB; i++) begin
            log_ax[i]   = '1;
            log_ay[i]   = '1;
            log_bx[i]   = '1;
            log_by[i]   = '1;
            log_last[i] = 1'bx;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        bp_hold = 0;
        @(negedge clk);
        chk("rst_ctrl", {bus.out_valid, bus.in_ready, bus.done, bus.last}, 32'd0);
        chk("rst_data", {bus.a_x, bus.a_y, bus.b_x, bus.b_y, bus.iter}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_op(input int abort_k, input int start_k, input bit gaps, input bit bp_at1);
        int k;
        int guard;
        bit hs;
        bit aborted;
        bit got;
        clear_log();
        model_push();
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_in     = cur_x[0];
        bus.y_in     = cur_y[0];
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k = 0;
        guard = 0;
        aborted = 1'b0;
        while (k < N && !aborted && guard < 300) begin
            bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.x_in     = cur_x[k];
            bus.y_in     = cur_y[k];
            bus.start    = (k == start_k);
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (hs) begin
                k++;
                if (bp_at1 && k == 2) bp_hold = 3;
                if (k == abort_k) aborted = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (guard >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got %0d digits expected %0d", k, N);
        end
        if (aborted) return;
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_nominal();
        cur_x[0] = 3'd1; cur_x[1] = 3'b110; cur_x[2] = 3'd3;   cur_x[3] = 3'd0;
        cur_y[0] = 3'd2; cur_y[1] = 3'd1;   cur_y[2] = 3'b111; cur_y[3] = 3'd3;
    endtask

    task automatic check_nominal_log(input string tag);
        chk({tag, "_b0_ax"}, 32'(log_ax[0]), 32'b000_000_000);
        chk({tag, "_b0_ay"}, 32'(log_ay[0]), 32'b010_000_000);
        chk({tag, "_b0_bx"}, 32'(log_bx[0]), 32'b001);
        chk({tag, "_b1_ax"}, 32'(log_ax[1]), 32'b001_000_000);
        chk({tag, "_b1_ay"}, 32'(log_ay[1]), 32'b010_001_000);
        chk({tag, "_b1_bx"}, 32'(log_bx[1]), 32'b110);
        chk({tag, "_b2_ax"}, 32'(log_ax[2]), 32'b001_110_000);
        chk({tag, "_b2_ay"}, 32'(log_ay[2]), 32'b010_001_111);
        chk({tag, "_b3_ax"}, 32'(log_ax[3]), 32'b001_110_011);
        chk({tag, "_b3_ay"}, 32'(log_ay[3]), 32'b010_001_111);
        chk({tag, "_b3_bxby"}, 32'({log_bx[3], log_by[3]}), 32'b000_011);
        chk({tag, "_b4_ax"}, 32'(log_ax[4]), 32'b001_110_011);
        chk({tag, "_b5_ay"}, 32'(log_ay[5]), 32'b010_001_111);
        chk({tag, "_b5_bxby"}, 32'({log_bx[5], log_by[5]}), 32'd0);
        chk({tag, "_b4_last"}, 32'(log_last[4]), 32'd0);
        chk({tag, "_b5_last"}, 32'(log_last[5]), 32'd1);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.x_in     = '0;
        bus.y_in     = '0;

        do_reset();
        // No beats and no acceptance without start.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.x_in     = 3'($urandom_range(0, 7));
            bus.y_in     = 3'($urandom_range(0, 7));
            @(negedge clk);
            chk("idle_no_ready", 32'({bus.in_ready, bus.out_valid}), 32'd0);
        end
        bus.in_valid = 1'b0;

        set_nominal();
        run_op(-1, -1, 1'b0, 1'b0);
        check_nominal_log("nom");

        set_nominal();
        run_op(-1, -1, 1'b0, 1'b1);
        check_nominal_log("bp");

        set_nominal();
        run_op(-1, 2, 1'b0, 1'b0);
        check_nominal_log("stign");

        set_nominal();
        run_op(2, -1, 1'b0, 1'b0);
        do_reset();
        cur_x[0] = 3'd3;
        for (int i = 1; i < N; i++) cur_x[i] = 3'(int'($urandom_range(0, 6)) - 3);
        for (int i = 0; i < N; i++) cur_y[i] = 3'(int'($urandom_range(0, 6)) - 3);
        run_op(-1, -1, 1'b0, 1'b0);
        chk("postrst_b0_ax", 32'(log_ax[0]), 32'd0);
        chk("postrst_b0_bx", 32'(log_bx[0]), 32'd3);

        rand_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                cur_x[i] = 3'(int'($urandom_range(0, 6)) - 3);
                cur_y[i] = 3'(int'($urandom_range(0, 6)) - 3);
            end
            run_op(-1, (t % 3 == 0) ? 1 : -1, 1'b1, 1'b0);
        end
        rand_ready = 1'b0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
